aes_core_sched: RTL
===================

Name: aes_core_sched

Overview:
- Two-requester scheduler that shares one AES cipher/decipher core.
- Arbitrates round-robin between requester 0 and requester 1, then launches one job on the core.
- Waits for the core's cipher_ready or decipher_ready, captures the 128-bit result and returns it with the requester ID over a valid/ready response channel.
- Sits between the host-side job queues and the AES core.

Parameters:
- DATA_W, 128, width of data and key words (core is fixed at 128).
- TIMEOUT_CYC, 64, cycles allowed in WAIT before error (only used with the optional feature).
- CNT_W, 8, width of the wait/timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester job valid.
- req_ready  out  2  per-requester accept strobe.
- req_mode  in  2  per-requester mode: 0 = encrypt, 1 = decrypt.
- req_key  in  2*DATA_W  per-requester key: cipher key for encrypt, round key 10 for decrypt.
- req_data  in  2*DATA_W  per-requester plaintext (encrypt) or ciphertext (decrypt).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester index of the result.
- rsp_data  out  DATA_W  ciphertext or plaintext result.
- rsp_err  out  1  job timed out; rsp_data is 0.
- plain_text_in  out  DATA_W  to core.
- cipher_key_in  out  DATA_W  to core.
- cipher_new_en  out  1  to core; 1-cycle launch pulse.
- cipher_text_in  out  DATA_W  to core.
- round_key_10  out  DATA_W  to core.
- EN  out  1  to core; core enable.
- cipher_text_out  in  DATA_W  from core.
- plain_text_out  in  DATA_W  from core.
- cipher_ready  in  1  from core; encrypt done.
- decipher_ready  in  1  from core; decrypt done.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, reset_n = 0): FSM to IDLE; rr_last = 1 (so requester 0 wins first); counter = 0. All outputs 0, including rsp_*, core data/key registers, cipher_new_en, EN, busy and req_ready.
- IDLE:
  - If any req_valid is set, grant one requester. When both are valid, grant the one not equal to rr_last.
  - In that same cycle, assert req_ready[g] combinationally for one cycle.
  - Latch mode, key and data into internal registers; set rr_last = g; go to ISSUE.
- ISSUE (1 cycle):
  - EN = 1 and cipher_new_en = 1.
  - Encrypt: plain_text_in = data, cipher_key_in = key; cipher_text_in and round_key_10 held at 0.
  - Decrypt: cipher_text_in = data, round_key_10 = key; plain_text_in and cipher_key_in held at 0.
  - Clear counter; go to WAIT.
- WAIT:
  - EN = 1, cipher_new_en = 0, data/key outputs held stable, counter increments each cycle.
  - Only the mode-matching ready is honoured: cipher_ready for encrypt, decipher_ready for decrypt. The other ready is ignored.
  - On the matching ready, capture the matching output (cipher_text_out or plain_text_out) into rsp_data, set rsp_err = 0 and rsp_id = g; go to RESP.
- RESP:
  - rsp_valid = 1 and EN = 0; rsp_data, rsp_id and rsp_err stay stable until rsp_valid && rsp_ready.
  - On the handshake, clear rsp_valid and go to IDLE.
  - No new grant is made in the handshake cycle.
- Latency: grant to cipher_new_en is 1 cycle. Core ready to rsp_valid is 1 cycle. Minimum request-to-request spacing is 3 cycles plus core latency.
- Simultaneous events:
  - req_valid changes while not in IDLE: ignored; req_ready stays 0.
  - Both readys arrive in WAIT: the mode-matching one wins.
  - Ready arrives in ISSUE: ignored.
- Reset mid-operation: immediate return to IDLE; the in-flight job is dropped with no response.
- busy = (state != IDLE).

Optional Feature:
- Macro: AES_SCHED_TIMEOUT_EN.
- Defined: in WAIT, when counter == TIMEOUT_CYC-1 with no matching ready, go to RESP with rsp_err = 1, rsp_data = 0 and rsp_id = g. EN drops in RESP. A matching ready arriving in that same cycle takes priority (normal response, rsp_err = 0).
- Undefined: no timeout; WAIT lasts indefinitely; rsp_err is tied to 0; the counter saturates at all-ones.

Test Plan:
- Encrypt, FIPS-197 vector:
  - Stimulus: requester 0 valid, mode 0, key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff.
  - Response: one cycle after grant, cipher_new_en pulses once with plain_text_in/cipher_key_in driven. Core model raises cipher_ready with 69c4e0d86a7b0430d8cdb78070b4c55a. Next cycle rsp_valid = 1, rsp_id = 0, rsp_err = 0, rsp_data = 69c4e0d86a7b0430d8cdb78070b4c55a.
- Decrypt:
  - Stimulus: requester 1, mode 1, key 13111d7fe3944a17f307a78b4d2b30c5, data 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: round_key_10 and cipher_text_in driven during ISSUE/WAIT. On decipher_ready, rsp_data = 00112233445566778899aabbccddeeff, rsp_id = 1.
- Round-robin: both requesters continuously valid for 4 jobs -> grant order 0,1,0,1; each req_ready is a 1-cycle pulse.
- Backpressure and wrong ready:
  - rsp_ready held 0 for 10 cycles -> rsp_* stable, no new grant, req_ready = 0.
  - decipher_ready pulsed during an encrypt job -> ignored, FSM stays in WAIT.
- Timeout (macro defined, TIMEOUT_CYC = 8): core never ready -> rsp_valid with rsp_err = 1 and rsp_data = 0 exactly 8 cycles after entering WAIT.
- Reset mid-WAIT: reset_n pulsed low -> all outputs 0 asynchronously, FSM in IDLE; the next request is granted to requester 0.

Source files
------------

// File: rtl/aes_core_sched.sv
// aes_core_sched: round-robin scheduler that shares one AES cipher/decipher core between two requesters.
// Optional macro AES_SCHED_TIMEOUT_EN adds a WAIT timeout that returns an error response.
module aes_core_sched #(
  parameter int DATA_W      = 128,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_mode,
  input  logic [2*DATA_W-1:0] req_key,
  input  logic [2*DATA_W-1:0] req_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   plain_text_in,
  output logic [DATA_W-1:0]   cipher_key_in,
  output logic                cipher_new_en,
  output logic [DATA_W-1:0]   cipher_text_in,
  output logic [DATA_W-1:0]   round_key_10,
  output logic                EN,
  input  logic [DATA_W-1:0]   cipher_text_out,
  input  logic [DATA_W-1:0]   plain_text_out,
  input  logic                cipher_ready,
  input  logic                decipher_ready,
  output logic                busy
);

  // Handshakes: a request transfers on the cycle req_valid[i] && req_ready[i]; a response
  // transfers on rsp_valid && rsp_ready, and rsp_* hold stable until that cycle.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  logic              rr_last;
  logic              job_id;
  logic              job_mode;
  logic [CNT_W-1:0]  cnt;
  logic              grant_any;
  logic              gnt;
  logic              sel_mode;
  logic              match;
  logic [DATA_W-1:0] sel_key;
  logic [DATA_W-1:0] sel_data;

  if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYC)) begin : g_cnt_w_check
    $error("CNT_W too narrow for TIMEOUT_CYC");
  end

  always_comb begin
    grant_any = (state == IDLE) && (req_valid != 2'b00);
    gnt       = (req_valid == 2'b11) ? ~rr_last : req_valid[1];
    sel_mode  = gnt ? req_mode[1] : req_mode[0];
    sel_key   = gnt ? req_key[2*DATA_W-1:DATA_W] : req_key[DATA_W-1:0];
    sel_data  = gnt ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
    match     = job_mode ? decipher_ready : cipher_ready;
    req_ready = 2'b00;
    if (reset_n && grant_any) req_ready = gnt ? 2'b10 : 2'b01;
  end

  assign busy = (state != IDLE);

`ifdef AES_SCHED_TIMEOUT_EN
  logic err_q;
  logic timeout;
  assign timeout = (cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      rr_last        <= 1'b1;
      job_id         <= 1'b0;
      job_mode       <= 1'b0;
      cnt            <= '0;
      rsp_valid      <= 1'b0;
      rsp_id         <= 1'b0;
      rsp_data       <= '0;
      plain_text_in  <= '0;
      cipher_key_in  <= '0;
      cipher_text_in <= '0;
      round_key_10   <= '0;
      cipher_new_en  <= 1'b0;
      EN             <= 1'b0;
`ifdef AES_SCHED_TIMEOUT_EN
      err_q          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            rr_last       <= gnt;
            job_id        <= gnt;
            job_mode      <= sel_mode;
            EN            <= 1'b1;
            cipher_new_en <= 1'b1;
            // The unused half of the core interface is held at zero.
            if (sel_mode) begin
              cipher_text_in <= sel_data;
              round_key_10   <= sel_key;
              plain_text_in  <= '0;
              cipher_key_in  <= '0;
            end else begin
              plain_text_in  <= sel_data;
              cipher_key_in  <= sel_key;
              cipher_text_in <= '0;
              round_key_10   <= '0;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cipher_new_en <= 1'b0;
          cnt           <= '0;
          state         <= WAIT;
        end
        WAIT: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (match) begin
            rsp_data  <= job_mode ? plain_text_out : cipher_text_out;
            rsp_id    <= job_id;
            rsp_valid <= 1'b1;
            EN        <= 1'b0;
            state     <= RESP;
`ifdef AES_SCHED_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
          end
`ifdef AES_SCHED_TIMEOUT_EN
          else if (timeout) begin
            rsp_data  <= '0;
            rsp_id    <= job_id;
            rsp_valid <= 1'b1;
            err_q     <= 1'b1;
            EN        <= 1'b0;
            state     <= RESP;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
